imm_encoder: RTL and testbench

- Inverse of the immediate extender: packs a 32-bit signed/unsigned immediate into the instruction bit positions for a given immsrc format.
- Merges the result over a base instruction word that carries opcode, register and funct fields.
- Used by the self-test instruction generator and the boot-ROM patcher. Range-checks each immediate and flags anything not representable.
- Two-stage valid/ready pipeline; full throughput of 1 word/cycle.

---
 rtl/imm_pkg.sv | 40 ++++
 rtl/imm_range_check.sv | 32 +++
 rtl/imm_encoder.sv | 104 ++++++++++
 tb/tb_imm_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared encodings, field masks and the stage-1 record for the immediate encoder.
`timescale 1ns/1ps
package imm_pkg;

  // Immediate format selectors (immsrc values); 3'b101..3'b111 are undefined.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Instruction bits owned by the immediate in each format; all other bits
  // come from the base instruction word.
  localparam logic [31:0] IMM_I_MASK = 32'hFFF0_0000;
  localparam logic [31:0] IMM_S_MASK = 32'hFE00_0F80;
  localparam logic [31:0] IMM_B_MASK = 32'hFE00_0F80;
  localparam logic [31:0] IMM_J_MASK = 32'hFFFF_F000;
  localparam logic [31:0] IMM_U_MASK = 32'hFFFF_F000;

  // Stage-1 payload: the accepted request plus its range-check verdict.
  typedef struct packed {
    logic [2:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] base_instr;
    logic        err;
  } s1_word_t;

  // Mask of overwritten bits for a format; undefined formats overwrite nothing.
  function automatic logic [31:0] imm_field_mask(input logic [2:0] immsrc);
    case (immsrc)
      IMM_I:   return IMM_I_MASK;
      IMM_S:   return IMM_S_MASK;
      IMM_B:   return IMM_B_MASK;
      IMM_J:   return IMM_J_MASK;
      IMM_U:   return IMM_U_MASK;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Flags immediates that the selected format cannot represent exactly.
`timescale 1ns/1ps
module imm_range_check
  import imm_pkg::*;
(
  input  logic [2:0]  immsrc,
  input  logic [31:0] imm,
  output logic        err
);

  logic fits_12;  // imm[31:11] all equal: 12-bit signed
  logic fits_13;  // imm[31:12] all equal: 13-bit signed
  logic fits_21;  // imm[31:20] all equal: 21-bit signed

  assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

  // Per-format representability; B/J offsets must also be halfword aligned.
  always_comb begin
    // NOTE: err gets a value before the case so no path leaves it unassigned and infers a latch.
    err = 1'b1;
    case (immsrc)
      IMM_I, IMM_S: err = !fits_12;
      IMM_B:        err = !fits_13 || imm[0];
      IMM_J:        err = !fits_21 || imm[0];
      IMM_U:        err = |imm[11:0];
      default:      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline that packs an immediate into the instruction
// bit positions for its format and merges it over a base instruction word.
`timescale 1ns/1ps
module imm_encoder
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       immsrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             imm_err,
  output logic [CNT_W-1:0] err_count
);

  logic       s1_valid;
  s1_word_t   s1;
  logic       range_err;
  logic       s2_adv;
  logic       s1_adv;
  logic [31:0] fields;
  logic [31:0] mask;
  logic [31:0] enc_instr;

  imm_range_check u_range_check (
    .immsrc (immsrc),
    .imm    (imm),
    .err    (range_err)
  );

  // Stage 2 can take a word when it is empty or being drained this cycle;
  // stage 1 can take one when it is empty or moving into stage 2.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;

  // Stage-1 occupancy flag.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every stage samples pre-edge values.
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Stage-1 payload capture on accept.
  always_ff @(posedge clk) begin
    // NOTE: the payload has no reset; it is only ever consumed while s1_valid is set.
    if (in_valid && in_ready) begin
      s1.immsrc     <= immsrc;
      s1.imm        <= imm;
      s1.base_instr <= base_instr;
      s1.err        <= range_err;
    end
  end

  // Field placement for the word held in stage 1.
  always_comb begin
    fields = 32'h0000_0000;
    case (s1.immsrc)
      IMM_I:   fields = {s1.imm[11:0], 20'b0};
      IMM_S:   fields = {s1.imm[11:5], 13'b0, s1.imm[4:0], 7'b0};
      IMM_B:   fields = {s1.imm[12], s1.imm[10:5], 13'b0, s1.imm[4:1], s1.imm[11], 7'b0};
      IMM_J:   fields = {s1.imm[20], s1.imm[10:1], s1.imm[11], s1.imm[19:12], 12'b0};
      IMM_U:   fields = {s1.imm[31:12], 12'b0};
      default: fields = 32'h0000_0000;
    endcase
    mask      = imm_field_mask(s1.immsrc);
    enc_instr = (s1.base_instr & ~mask) | (fields & mask);
  end

  // Stage-2 output register; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr     <= 32'h0000_0000;
      imm_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_adv) begin
        instr   <= enc_instr;
        imm_err <= s1.err;
      end
    end
  end

  // Saturating count of erroneous words actually handed to the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (out_valid && out_ready && imm_err && !(&err_count)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: vector table, scoreboard, and
// hand-written backpressure, throughput, saturation and reset sequences.
`timescale 1ns/1ps
module tb_imm_encoder;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       immsrc = 3'b000;
  logic [31:0]      imm = 32'h0;
  logic [31:0]      base_instr = 32'h0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      instr;
  logic             imm_err;
  logic [CNT_W-1:0] err_count;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  s;
    logic [31:0] i;
    logic [31:0] b;
    logic [31:0] ei;
    logic        ee;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   acc_count = 0;
  exp_t sb[$];
  int   acc_cyc[$];
  int   hand_cyc[$];
  exp_t mon_e;
  bit   bp_done;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .immsrc     (immsrc),
    .imm        (imm),
    .base_instr (base_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .imm_err    (imm_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Independent reference: bit placement by concatenation, range by signed compare.
  function automatic exp_t model(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
    exp_t e;
    int   v;
    v = $signed(i);
    case (s)
      3'd0: begin e.instr = {i[11:0], b[19:0]};                                e.err = (v < -2048) || (v > 2047); end
      3'd1: begin e.instr = {i[11:5], b[24:12], i[4:0], b[6:0]};               e.err = (v < -2048) || (v > 2047); end
      3'd2: begin e.instr = {i[12], i[10:5], b[24:12], i[4:1], i[11], b[6:0]}; e.err = (v < -4096) || (v > 4095) || i[0]; end
      3'd3: begin e.instr = {i[20], i[10:1], i[11], i[19:12], b[11:0]};        e.err = (v < -1048576) || (v > 1048575) || i[0]; end
      3'd4: begin e.instr = {i[31:12], b[11:0]};                               e.err = (i[11:0] != 12'h000); end
      default: begin e.instr = b; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Monitor: records accepts, and compares every handoff against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        acc_count++;
        acc_cyc.push_back(cycle);
      end
      if (out_valid && out_ready) begin
        hand_cyc.push_back(cycle);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got instr=%h with nothing outstanding, required no output", instr);
        end else begin
          mon_e = sb.pop_front();
          check("instr", instr, mon_e.instr);
          check("imm_err", {31'b0, imm_err}, {31'b0, mon_e.err});
        end
      end
    end
  end

  // Drive one request (called at posedge+1) and push its expectation on accept.
  task automatic send(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b,
                      input logic [31:0] ei, input logic ee);
    exp_t e;
    immsrc     = s;
    imm        = i;
    base_instr = b;
    in_valid   = 1'b1;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready) begin
        e.instr = ei;
        e.err   = ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
    exp_t e;
    e = model(s, i, b);
    send(s, i, b, e.instr, e.err);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int w = 0; w < 100; w++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_outstanding", sb.size(), 0);
  endtask

  // Random request, mostly in range, in a random defined format.
  task automatic send_random();
    logic [31:0] r;
    logic [2:0]  s;
    logic [31:0] i;
    r = $urandom;
    s = 3'($urandom_range(0, 4));
    case (s)
      3'd0, 3'd1: i = {{20{r[11]}}, r[11:0]};
      3'd2:       i = {{19{r[12]}}, r[12:1], 1'b0};
      3'd3:       i = {{11{r[20]}}, r[20:1], 1'b0};
      default:    i = {r[31:12], 12'h000};
    endcase
    if ($urandom_range(0, 7) == 0) i = $urandom;
    send_model(s, i, $urandom);
  endtask

  task automatic flood_errors(input int n);
    logic [31:0] b;
    for (int k = 0; k < n; k++) begin
      b = $urandom;
      send(3'b110, 32'h0, b, b, 1'b1);
    end
    idle();
    drain();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[12];
    int   held;
    logic held_err;

    vt[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
    vt[1]  = '{3'b001, 32'h0000_0008, 32'h0051_2023, 32'h0051_2423, 1'b0};
    vt[2]  = '{3'b010, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
    vt[3]  = '{3'b011, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0};
    vt[4]  = '{3'b100, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0};
    vt[5]  = '{3'b001, 32'hFFFF_FFFF, 32'h0051_2023, 32'hFE51_2FA3, 1'b0};
    vt[6]  = '{3'b011, 32'h000F_FFFE, 32'h0000_00EF, 32'h7FFF_F0EF, 1'b0};
    vt[7]  = '{3'b000, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0};
    vt[8]  = '{3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
    vt[9]  = '{3'b010, 32'h0000_0005, 32'h0000_0063, 32'h0000_0263, 1'b1};
    vt[10] = '{3'b100, 32'h0000_1001, 32'h0000_02B7, 32'h0000_12B7, 1'b1};
    vt[11] = '{3'b101, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1};

    // Reset with a request presented: it must be dropped.
    reset      = 1'b1;
    in_valid   = 1'b1;
    immsrc     = 3'b000;
    imm        = 32'h5;
    base_instr = 32'h13;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_imm_err", {31'b0, imm_err}, 32'd0);
    check("rst_err_count", {16'b0, err_count}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("dropped_out_valid", {31'b0, out_valid}, 32'd0);

    // Vector table: good words then errors, all through the scoreboard.
    for (int k = 0; k < 12; k++) begin
      send(vt[k].s, vt[k].i, vt[k].b, vt[k].ei, vt[k].ee);
      if (k == 7) begin
        idle();
        drain();
        check("err_count_good", {16'b0, err_count}, 32'd0);
      end
    end
    idle();
    drain();
    check("err_count_four", {16'b0, err_count}, 32'd4);

    // Backpressure: four requests against a stalled consumer.
    out_ready = 1'b0;
    acc_count = 0;
    hand_cyc.delete();
    bp_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send_model(3'($urandom_range(0, 4)), $urandom, $urandom);
        in_valid = 1'b0;
        bp_done  = 1'b1;
      end
    join_none
    repeat (3) @(negedge clk);
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    held     = instr;
    held_err = imm_err;
    repeat (3) @(negedge clk);
    check("bp_accepts", acc_count, 32'd2);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_instr_hold", instr, held);
    check("bp_err_hold", {31'b0, imm_err}, {31'b0, held_err});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int w = 0; w < 50 && !bp_done; w++) begin
      @(posedge clk);
      #1;
    end
    check("bp_sender_done", {31'b0, bp_done}, 32'd1);
    drain();
    check("bp_words", hand_cyc.size(), 32'd4);
    if (hand_cyc.size() == 4) check("bp_one_per_cycle", hand_cyc[3] - hand_cyc[0], 32'd3);

    // Latency and throughput: 16 back-to-back requests.
    acc_cyc.delete();
    hand_cyc.delete();
    for (int k = 0; k < 16; k++) send_random();
    idle();
    drain();
    check("tp_accepts", acc_cyc.size(), 32'd16);
    check("tp_words", hand_cyc.size(), 32'd16);
    if (acc_cyc.size() == 16 && hand_cyc.size() == 16) begin
      check("tp_latency", hand_cyc[0] - acc_cyc[0], 32'd2);
      check("tp_accept_rate", acc_cyc[15] - acc_cyc[0], 32'd15);
      check("tp_output_rate", hand_cyc[15] - hand_cyc[0], 32'd15);
    end

    // Saturation of err_count (currently 4 plus any random errors above).
    flood_errors(65530 - int'(err_count) + 4);
    check("sat_below_max", {16'b0, err_count}, 32'h0000_FFFE);
    flood_errors(1);
    check("sat_at_max", {16'b0, err_count}, 32'h0000_FFFF);
    flood_errors(5);
    check("sat_no_wrap", {16'b0, err_count}, 32'h0000_FFFF);

    // Reset with two words buffered: they must vanish.
    out_ready = 1'b0;
    send_model(3'b000, 32'h0000_0010, 32'h0000_0013);
    send_model(3'b100, 32'h0000_1001, 32'h0000_0037);
    idle();
    check("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_err_count", {16'b0, err_count}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    hand_cyc.delete();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_words", hand_cyc.size(), 32'd0);
    send_model(3'b010, 32'hFFFF_F000, 32'h0000_0063);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
